// File: rtl/l1d_pkg.sv
// l1d_pkg: shared types and helpers for the L1 data cache miss path
package l1d_pkg;
    localparam int L1D_PADDR_BITS  = 22;
    localparam int L1D_LINE_BYTES  = 64;
    localparam int L1D_OFFSET_BITS = $clog2(L1D_LINE_BYTES);
    localparam int L1D_TAG_BITS    = 10;

    typedef struct packed {
        logic [L1D_PADDR_BITS-1:0] paddr;
        logic                      we;
        logic [63:0]               data;
        logic [L1D_TAG_BITS-1:0]   tag;
    } mshr_target_t;

    typedef enum logic [1:0] {FREE, WAIT_ISSUE, WAIT_FILL, REPLAY} mshr_state_e;

    function automatic logic [L1D_PADDR_BITS-L1D_OFFSET_BITS-1:0] line_addr(input logic [L1D_PADDR_BITS-1:0] paddr);
        return paddr[L1D_PADDR_BITS-1:L1D_OFFSET_BITS];
    endfunction
endpackage

// File: rtl/mshr_target_fifo.sv
// mshr_target_fifo: in-order queue of targets waiting on one MSHR entry
module mshr_target_fifo
    import l1d_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_in,
    input  logic                         rst_N_in,
    input  logic                         push,
    input  mshr_target_t                 push_data,
    input  logic                         pop,
    output mshr_target_t                 head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    mshr_target_t mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_in)
        if (do_push) mem[wr_ptr] <= push_data;

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/l1d_mshr_file.sv
// l1d_mshr_file: miss-status holding registers for the non-blocking L1 data cache;
// merges misses per line, issues one lower-cache request per line and replays targets in order.
module l1d_mshr_file
    import l1d_pkg::*;
#(
    parameter int PADDR_BITS       = L1D_PADDR_BITS,
    parameter int B                = L1D_LINE_BYTES,
    parameter int MSHR_COUNT       = 4,
    parameter int TARGETS_PER_MSHR = 4,
    parameter int TAG_BITS         = L1D_TAG_BITS
) (
    input  logic                              clk_in,
    input  logic                              rst_N_in,
    input  logic                              miss_valid_in,
    output logic                              miss_ready_out,
    input  logic [PADDR_BITS-1:0]             miss_paddr_in,
    input  logic                              miss_we_in,
    input  logic [63:0]                       miss_data_in,
    input  logic [TAG_BITS-1:0]               miss_tag_in,
    output logic                              lc_req_valid_out,
    input  logic                              lc_req_ready_in,
    output logic [PADDR_BITS-1:0]             lc_req_addr_out,
    input  logic                              lc_fill_valid_in,
    output logic                              lc_fill_ready_out,
    input  logic [PADDR_BITS-1:0]             lc_fill_addr_in,
    output logic                              replay_valid_out,
    input  logic                              replay_ready_in,
    output logic [PADDR_BITS-1:0]             replay_paddr_out,
    output logic                              replay_we_out,
    output logic [63:0]                       replay_data_out,
    output logic [TAG_BITS-1:0]               replay_tag_out,
    output logic                              replay_last_out,
    output logic [$clog2(MSHR_COUNT+1)-1:0]   occupancy_out,
    output logic                              unexp_fill_out
);
    localparam int OFFSET_BITS = $clog2(B);
    localparam int LW = PADDR_BITS - OFFSET_BITS;
    localparam int IW = MSHR_COUNT > 1 ? $clog2(MSHR_COUNT) : 1;
    localparam int CW = $clog2(TARGETS_PER_MSHR + 1);
    localparam int OW = $clog2(MSHR_COUNT + 1);

    mshr_state_e state [MSHR_COUNT];
    logic [LW-1:0] ctag [MSHR_COUNT];
    mshr_target_t head [MSHR_COUNT];
    logic [CW-1:0] count [MSHR_COUNT];
    logic [MSHR_COUNT-1:0] full, empty, push, pop;
    logic [LW-1:0] miss_line, fill_line, iss_line;
    logic [IW-1:0] hit_idx, alloc_idx, fill_idx, rep_idx, iss_idx, req_idx;
    logic hit, rhit, any_free, fhit, rep_any, iss_any;
    logic accept, alloc, fill_hs, req_hs, rep_hs;
    mshr_target_t miss_tgt, rep_tgt;

    assign miss_line = line_addr(miss_paddr_in);
    assign fill_line = line_addr(lc_fill_addr_in);
    assign miss_tgt  = '{paddr: miss_paddr_in, we: miss_we_in, data: miss_data_in, tag: miss_tag_in};

    // Descending scan so the lowest matching index wins every encoder.
    always_comb begin
        hit = 1'b0;
        rhit = 1'b0;
        any_free = 1'b0;
        fhit = 1'b0;
        rep_any = 1'b0;
        hit_idx = '0;
        alloc_idx = '0;
        fill_idx = '0;
        rep_idx = '0;
        occupancy_out = '0;
        for (int i = MSHR_COUNT - 1; i >= 0; i--) begin
            if ((state[i] == WAIT_ISSUE || state[i] == WAIT_FILL) && ctag[i] == miss_line) begin
                hit = 1'b1;
                hit_idx = IW'(i);
            end
            if (state[i] == REPLAY) begin
                rep_any = 1'b1;
                rep_idx = IW'(i);
                rhit = rhit || ctag[i] == miss_line;
            end
            if (state[i] == FREE) begin
                any_free = 1'b1;
                alloc_idx = IW'(i);
            end
            if (state[i] == WAIT_FILL && ctag[i] == fill_line) begin
                fhit = 1'b1;
                fill_idx = IW'(i);
            end
            occupancy_out = occupancy_out + OW'(state[i] != FREE);
        end
    end

    assign miss_ready_out    = rst_N_in && !rhit && (hit ? !full[hit_idx] : any_free);
    assign lc_fill_ready_out = rst_N_in && !rep_any;
    assign accept            = miss_valid_in && miss_ready_out;
    assign alloc             = accept && !hit;
    assign fill_hs           = lc_fill_valid_in && lc_fill_ready_out;
    assign req_hs            = lc_req_valid_out && lc_req_ready_in;

    assign rep_tgt          = head[rep_idx];
    assign replay_valid_out = rep_any && !empty[rep_idx];
    assign rep_hs           = replay_valid_out && replay_ready_in;
    assign replay_paddr_out = replay_valid_out ? rep_tgt.paddr : '0;
    assign replay_we_out    = replay_valid_out && rep_tgt.we;
    assign replay_data_out  = replay_valid_out ? rep_tgt.data : '0;
    assign replay_tag_out   = replay_valid_out ? rep_tgt.tag : '0;
    assign replay_last_out  = replay_valid_out && count[rep_idx] == CW'(1);

    // An entry allocated this cycle is already a candidate, giving one-cycle request latency.
    always_comb begin
        iss_any = 1'b0;
        iss_idx = '0;
        for (int i = MSHR_COUNT - 1; i >= 0; i--)
            if ((state[i] == WAIT_ISSUE && !(req_hs && req_idx == IW'(i))) || (alloc && alloc_idx == IW'(i))) begin
                iss_any = 1'b1;
                iss_idx = IW'(i);
            end
    end

    assign iss_line = (alloc && alloc_idx == iss_idx) ? miss_line : ctag[iss_idx];

    for (genvar e = 0; e < MSHR_COUNT; e++) begin : g_ent
        assign push[e] = accept && (hit ? hit_idx == IW'(e) : alloc_idx == IW'(e));
        assign pop[e]  = rep_hs && rep_idx == IW'(e);
        mshr_target_fifo #(.DEPTH(TARGETS_PER_MSHR)) u_fifo (
            .clk_in    (clk_in),
            .rst_N_in  (rst_N_in),
            .push      (push[e]),
            .push_data (miss_tgt),
            .pop       (pop[e]),
            .head      (head[e]),
            .full      (full[e]),
            .empty     (empty[e]),
            .count     (count[e])
        );
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            for (int i = 0; i < MSHR_COUNT; i++) begin
                state[i] <= FREE;
                ctag[i]  <= '0;
            end
            lc_req_valid_out <= 1'b0;
            lc_req_addr_out  <= '0;
            req_idx          <= '0;
            unexp_fill_out   <= 1'b0;
        end else begin
            for (int i = 0; i < MSHR_COUNT; i++) begin
                case (state[i])
                    FREE:       if (alloc && alloc_idx == IW'(i)) state[i] <= WAIT_ISSUE;
                    WAIT_ISSUE: if (req_hs && req_idx == IW'(i)) state[i] <= WAIT_FILL;
                    WAIT_FILL:  if (fill_hs && fhit && fill_idx == IW'(i)) state[i] <= REPLAY;
                    REPLAY:     if (pop[i] && replay_last_out) state[i] <= FREE;
                    default:    state[i] <= FREE;
                endcase
                if (alloc && alloc_idx == IW'(i)) ctag[i] <= miss_line;
            end
            if (!lc_req_valid_out || lc_req_ready_in) begin
                lc_req_valid_out <= iss_any;
                lc_req_addr_out  <= iss_any ? {iss_line, {OFFSET_BITS{1'b0}}} : '0;
                req_idx          <= iss_idx;
            end
            unexp_fill_out <= fill_hs && !fhit;
        end
    end
endmodule
